// File: rtl/bitstream_packer_pkg.sv
// Shared widths for the variable-length bit packer.
package bitstream_packer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned REST_W = 3;

endpackage

// File: rtl/bitstream_align.sv
// Masks the incoming code bits to their length and places them directly after
// the bits already held in the left-aligned accumulator.
module bitstream_align
    import bitstream_packer_pkg::*;
(
    input  logic [LEN_W-1:0]  acclen,
    input  logic [LEN_W-1:0]  ilength,
    input  logic [DATA_W-1:0] idata,
    output logic [ACC_W-1:0]  placed
);

    logic [ACC_W-1:0] mask;
    logic [ACC_W-1:0] masked;
    logic [LEN_W:0]   shamt;

    // Mask off the upper garbage, then shift to offset 64 - acclen - ilength.
    // The offset reaches 64 only when both lengths are zero; the masked value
    // is then zero, so the shift result does not matter.
    always_comb begin
        mask   = ~({ACC_W{1'b1}} << ilength);
        masked = {{(ACC_W - DATA_W){1'b0}}, idata} & mask;
        shamt  = (LEN_W + 1)'(ACC_W) - {1'b0, acclen} - {1'b0, ilength};
        placed = masked << shamt;
    end

endmodule

// File: rtl/bitstream_packer.sv
// Appends 0..32 right-aligned code bits per cycle MSB-first to a bitstream and
// emits each completed 32-bit word as a one-cycle pulse.
module bitstream_packer
    import bitstream_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  ilength,
    input  logic [DATA_W-1:0] idata,
    output logic [REST_W-1:0] rest,
    output logic              ovalid,
    output logic [DATA_W-1:0] odata
);

    logic [ACC_W-1:0]  acc_q, acc_d, acc_next, placed;
    logic [LEN_W-1:0]  acclen_q, acclen_d, len_c;
    logic [LEN_W:0]    sum;
    logic              word_done;
    logic [DATA_W-1:0] odata_q;
    logic              ovalid_q;
    logic [REST_W-1:0] rest_q;

    // Lengths above a full word are clamped to a full word.
    always_comb begin
        len_c = (ilength > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : ilength;
    end

    bitstream_align u_align (
        .acclen  (acclen_q),
        .ilength (len_c),
        .idata   (idata),
        .placed  (placed)
    );

    // Merge new bits and decide whether the top word is complete.
    always_comb begin
        acc_next  = acc_q | placed;
        sum       = {1'b0, acclen_q} + {1'b0, len_c};
        word_done = (sum >= (LEN_W + 1)'(DATA_W));
        acc_d     = acc_next;
        acclen_d  = sum[LEN_W-1:0];
        if (word_done) begin
            acc_d    = acc_next << DATA_W;
            acclen_d = LEN_W'(sum - (LEN_W + 1)'(DATA_W));
        end
    end

    // Accumulator, output word and byte-alignment distance registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            acclen_q <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            rest_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            acclen_q <= acclen_d;
            ovalid_q <= word_done;
            if (word_done) begin
                odata_q <= acc_next[ACC_W-1:ACC_W-DATA_W];
            end
            // (8 - acclen % 8) % 8 is the 3-bit negation of the low bits.
            rest_q   <= -acclen_d[REST_W-1:0];
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign rest   = rest_q;

endmodule

// File: tb/tb_bitstream_packer.sv
// Directed bench for bitstream_packer: inputs driven 1 time unit after the
// rising edge, outputs sampled 1 time unit after the edge that consumed them.
module tb_bitstream_packer;

    logic        clk;
    logic        rst;
    logic [5:0]  ilength;
    logic [31:0] idata;
    logic [2:0]  rest;
    logic        ovalid;
    logic [31:0] odata;

    int checks;
    int failures;

    bitstream_packer dut (
        .clk     (clk),
        .rst     (rst),
        .ilength (ilength),
        .idata   (idata),
        .rest    (rest),
        .ovalid  (ovalid),
        .odata   (odata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input for one cycle; returns just after the consuming edge.
    task automatic send(input logic [5:0] len, input logic [31:0] data);
        ilength = len;
        idata   = data;
        @(posedge clk);
        #1;
        ilength = '0;
        idata   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ilength = '0;
        idata = '0;
        #12;
        checks++;
        if (ovalid !== 1'b0) begin
            failures++; $display("FAIL reset_ovalid got=%b want=0", ovalid);
        end
        checks++;
        if (odata !== 32'h0) begin
            failures++; $display("FAIL reset_odata got=%h want=0", odata);
        end
        checks++;
        if (rest !== 3'd0) begin
            failures++; $display("FAIL reset_rest got=%0d want=0", rest);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_words();
        logic [31:0] w [3] = '{32'h10101010, 32'h20202020, 32'h30303030};
        for (int i = 0; i < 3; i++) begin
            send(6'd32, w[i]);
            checks++;
            if (ovalid !== 1'b1 || odata !== w[i]) begin
                failures++;
                $display("FAIL full_word%0d got v=%b d=%h want v=1 d=%h", i, ovalid, odata, w[i]);
            end
        end
        send(6'd0, 32'hFFFFFFFF);
        checks++;
        if (ovalid !== 1'b0 || odata !== 32'h30303030) begin
            failures++;
            $display("FAIL full_idle_hold got v=%b d=%h want v=0 d=30303030", ovalid, odata);
        end
    endtask

    task automatic test_half_words();
        logic [31:0] d [4] = '{32'hffff4040, 32'hffff5050, 32'hffff6060, 32'hffff7070};
        logic [31:0] exp_w [4] = '{32'h0, 32'h40405050, 32'h0, 32'h60607070};
        for (int i = 0; i < 4; i++) begin
            send(6'd16, d[i]);
            checks++;
            if (ovalid !== i[0] || (i[0] && odata !== exp_w[i])) begin
                failures++;
                $display("FAIL half%0d got v=%b d=%h want v=%b d=%h",
                         i, ovalid, odata, i[0], exp_w[i]);
            end
        end
    endtask

    task automatic test_mixed_lengths();
        logic [5:0]  lens [15] = '{1, 7, 2, 6, 3, 5, 4, 4, 5, 3, 6, 2, 7, 1, 8};
        logic [31:0] vals [15] = '{0, 32'h7F, 0, 32'h3F, 0, 32'h1F, 0, 32'h0F,
                                   0, 32'h07, 0, 32'h03, 0, 32'h01, 0};
        logic [31:0] junk;
        logic        exp_v;
        logic [31:0] exp_d;
        for (int i = 0; i < 15; i++) begin
            // Garbage above the valid length must be ignored.
            junk  = 32'hA5A5A5A5 << lens[i];
            send(lens[i], vals[i] | junk);
            exp_v = (i == 7) || (i == 14);
            exp_d = (i == 7) ? 32'h7F3F1F0F : 32'h07030100;
            checks++;
            if (ovalid !== exp_v || (exp_v && odata !== exp_d)) begin
                failures++;
                $display("FAIL mixed%0d got v=%b d=%h want v=%b d=%h", i, ovalid, odata, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_sub_byte();
        send(6'd16, 32'h0000a0a0);
        checks++;
        if (ovalid !== 1'b0 || rest !== 3'd0) begin
            failures++; $display("FAIL sub_16 got v=%b rest=%0d want v=0 rest=0", ovalid, rest);
        end
        send(6'd3, 32'h5);
        checks++;
        if (rest !== 3'd5) begin
            failures++; $display("FAIL sub_3a rest got=%0d want=5", rest);
        end
        send(6'd3, 32'h2);
        checks++;
        if (rest !== 3'd2) begin
            failures++; $display("FAIL sub_3b rest got=%0d want=2", rest);
        end
        send(6'd2, 32'h2);
        checks++;
        if (rest !== 3'd0 || ovalid !== 1'b0) begin
            failures++; $display("FAIL sub_2 got v=%b rest=%0d want v=0 rest=0", ovalid, rest);
        end
        // 9-bit piece crosses the word boundary: 8 bits close the word, 1 stays.
        send(6'd9, 32'h155);
        checks++;
        if (ovalid !== 1'b1 || odata !== 32'hA0A0AAAA || rest !== 3'd7) begin
            failures++;
            $display("FAIL sub_9 got v=%b d=%h rest=%0d want v=1 d=a0a0aaaa rest=7", ovalid, odata, rest);
        end
        send(6'd7, 32'h2A);
        checks++;
        if (ovalid !== 1'b0 || rest !== 3'd0) begin
            failures++; $display("FAIL sub_7 got v=%b rest=%0d want v=0 rest=0", ovalid, rest);
        end
        send(6'd24, 32'hFF123456);
        checks++;
        if (ovalid !== 1'b1 || odata !== 32'hAA123456) begin
            failures++; $display("FAIL sub_split got v=%b d=%h want v=1 d=aa123456", ovalid, odata);
        end
    endtask

    task automatic test_byte_align();
        for (int i = 0; i < 2; i++) begin
            send(6'd3, 32'h0);
            checks++;
            if (rest !== 3'd5) begin
                failures++; $display("FAIL align%0d_rest got=%0d want=5", i, rest);
            end
            send({3'b000, rest}, 32'hFFFFFFFF);
            checks++;
            if (rest !== 3'd0 || ovalid !== 1'b0) begin
                failures++; $display("FAIL align%0d_fill got v=%b rest=%0d want v=0 rest=0", i, ovalid, rest);
            end
        end
        send(6'd16, 32'h1111);
        checks++;
        if (ovalid !== 1'b1 || odata !== 32'h1F1F1111 || rest !== 3'd0) begin
            failures++;
            $display("FAIL align_word got v=%b d=%h rest=%0d want v=1 d=1f1f1111 rest=0", ovalid, odata, rest);
        end
        // rest is 0 here, so this fill is a zero-length no-op.
        send({3'b000, rest}, 32'hFFFFFFFF);
        checks++;
        if (ovalid !== 1'b0 || odata !== 32'h1F1F1111 || rest !== 3'd0) begin
            failures++;
            $display("FAIL align_noop got v=%b d=%h rest=%0d want v=0 d=1f1f1111 rest=0", ovalid, odata, rest);
        end
        send(6'd32, 32'hCAFEF00D);
        checks++;
        if (ovalid !== 1'b1 || odata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL align_after_noop got v=%b d=%h want v=1 d=cafef00d", ovalid, odata);
        end
    endtask

    task automatic test_clamp();
        send(6'd40, 32'h12345678);
        checks++;
        if (ovalid !== 1'b1 || odata !== 32'h12345678 || rest !== 3'd0) begin
            failures++;
            $display("FAIL clamp got v=%b d=%h rest=%0d want v=1 d=12345678 rest=0", ovalid, odata, rest);
        end
    endtask

    task automatic test_mid_reset();
        send(6'd12, 32'hFFFFFABC);
        checks++;
        if (rest !== 3'd4 || ovalid !== 1'b0) begin
            failures++; $display("FAIL mreset_pre got v=%b rest=%0d want v=0 rest=4", ovalid, rest);
        end
        send(6'd0, 32'h0);
        rst = 1'b0;
        #2;
        checks++;
        if (ovalid !== 1'b0 || rest !== 3'd0 || odata !== 32'h0) begin
            failures++;
            $display("FAIL mreset_async got v=%b d=%h rest=%0d want v=0 d=0 rest=0", ovalid, odata, rest);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(6'd32, 32'hDEADBEEF);
        checks++;
        if (ovalid !== 1'b1 || odata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL mreset_after got v=%b d=%h want v=1 d=deadbeef", ovalid, odata);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_full_words();
        test_half_words();
        test_mixed_lengths();
        test_sub_byte();
        test_byte_align();
        test_clamp();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
